// File: rtl/data_sram_responder.sv
// Data-memory responder for the 5-stage pipeline: byte-enable stores, registered read word,
// optional wait states with stall request. Optional range check: DSRAM_RANGE_CHECK_EN.
module data_sram_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
`ifdef DSRAM_RANGE_CHECK_EN
    output logic        addr_err,
`endif
    output logic [1:0]  dbg_state_o
);
    // Request/stall handshake: a request is presented with data_sram_en=1 and held by the
    // pipeline for as long as stallreq=1; the cycle in which stallreq drops (DONE, or every
    // cycle when WAIT_CYCLES==0) completes it and rdata is valid for a completed read.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [31:0]       mem_q [DEPTH];
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic [31:0]       lat_addr_q, lat_wdata_q;
    logic [3:0]        lat_wen_q;

    logic              do_access;
    logic [31:0]       acc_addr, acc_wdata, offset;
    logic [3:0]        acc_wen;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              unused_offset_bits;

    always_comb begin
        acc_addr  = lat_addr_q;
        acc_wen   = lat_wen_q;
        acc_wdata = lat_wdata_q;
        do_access = 1'b0;
        stallreq  = 1'b0;
        if (WAIT_CYCLES == 0) begin
            do_access = data_sram_en;
            acc_addr  = data_sram_addr;
            acc_wen   = data_sram_wen;
            acc_wdata = data_sram_wdata;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stallreq = data_sram_en;
                    if (WAIT_CYCLES == 1) begin
                        do_access = data_sram_en;
                        acc_addr  = data_sram_addr;
                        acc_wen   = data_sram_wen;
                        acc_wdata = data_sram_wdata;
                    end
                end
                S_WAIT: begin
                    stallreq  = 1'b1;
                    do_access = (cnt_q == CNT_W'(1));
                end
                default: ;
            endcase
        end
        // Reset on the completing edge aborts the access, including a pending write.
        if (rst) do_access = 1'b0;
    end

`ifdef DSRAM_RANGE_CHECK_EN
    localparam logic [32:0] SPAN_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    logic addr_err_q;
    assign in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, acc_addr} < SPAN_END);
    assign offset   = acc_addr - BASE_ADDR;
    assign addr_err = addr_err_q;
`else
    assign in_range = 1'b1;
    assign offset   = acc_addr;
`endif

    assign idx                = offset[ADDR_W+1:2];
    assign unused_offset_bits = ^{offset[31:ADDR_W+2], offset[1:0]};

    always_ff @(posedge clk) begin
        if (do_access && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wen[b]) mem_q[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            lat_addr_q  <= '0;
            lat_wen_q   <= '0;
            lat_wdata_q <= '0;
`ifdef DSRAM_RANGE_CHECK_EN
            addr_err_q  <= 1'b0;
`endif
        end else begin
`ifdef DSRAM_RANGE_CHECK_EN
            addr_err_q <= do_access && !in_range;
`endif
            if (do_access && (acc_wen == 4'b0000)) begin
                rdata_q <= in_range ? mem_q[idx] : 32'h0;
            end
            if (WAIT_CYCLES != 0) begin
                case (state_q)
                    S_IDLE: begin
                        if (data_sram_en) begin
                            lat_addr_q  <= data_sram_addr;
                            lat_wen_q   <= data_sram_wen;
                            lat_wdata_q <= data_sram_wdata;
                            if (WAIT_CYCLES == 1) begin
                                state_q <= S_DONE;
                            end else begin
                                cnt_q   <= CNT_LOAD;
                                state_q <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_q <= S_DONE;
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a single-cycle instance and a 3-wait-state instance checked
// against a word-array model of the memory and the expected stall count per access.
module tb_data_sram_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en0, en3;
    logic [3:0]  wen0, wen3;
    logic [31:0] addr0, addr3, wdata0, wdata3, rdata0, rdata3;
    logic        stall0, stall3;
    logic [1:0]  dbg0, dbg3;
`ifdef DSRAM_RANGE_CHECK_EN
    logic        addr_err0, addr_err3;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m0 [16];
    logic [31:0] m3 [16];
    logic [31:0] exp0, exp3;

    data_sram_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0),
        .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
        .stallreq(stall0),
`ifdef DSRAM_RANGE_CHECK_EN
        .addr_err(addr_err0),
`endif
        .dbg_state_o(dbg0)
    );

    data_sram_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3),
        .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
        .stallreq(stall3),
`ifdef DSRAM_RANGE_CHECK_EN
        .addr_err(addr_err3),
`endif
        .dbg_state_o(dbg3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wen,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Word index in bits [5:2]; bits [11:6] zero; low byte bits and (without range check)
    // high bits random, which must alias onto the same word.
    function automatic logic [31:0] make_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[11:6] = '0;
        a[5:2]  = idx[3:0];
`ifdef DSRAM_RANGE_CHECK_EN
        a[31:12] = '0;
`endif
        return a;
    endfunction

    task automatic acc0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wd;
        tick();
        en0 = 1'b0; wen0 = 4'h0;
        if (wen == 4'h0) exp0 = m0[addr[5:2]];
        else m0[addr[5:2]] = merge(m0[addr[5:2]], wen, wd);
        n_vec++;
        if (rdata0 !== exp0) begin
            n_err++;
            $display("FAIL n0_rdata addr=%h wen=%b: got %h expected %h", addr, wen, rdata0, exp0);
        end
        n_vec++;
        if (stall0 !== 1'b0) begin
            n_err++;
            $display("FAIL n0_stallreq: got %b expected 0", stall0);
        end
    endtask

    task automatic acc3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        int stalls;
        en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wd;
        #1;
        stalls = 0;
        while (stall3 === 1'b1 && stalls < 10) begin
            stalls++;
            tick();
            if (stall3 === 1'b1) begin
                addr3 = $urandom; wdata3 = $urandom; wen3 = 4'($urandom);
            end
        end
        if (wen == 4'h0) exp3 = m3[addr[5:2]];
        else m3[addr[5:2]] = merge(m3[addr[5:2]], wen, wd);
        n_vec++;
        if (stalls != 3) begin
            n_err++;
            $display("FAIL n3_stall_cycles addr=%h: got %0d expected 3", addr, stalls);
        end
        n_vec++;
        if (rdata3 !== exp3) begin
            n_err++;
            $display("FAIL n3_rdata_done addr=%h wen=%b: got %h expected %h", addr, wen, rdata3, exp3);
        end
        tick();
        en3 = 1'b0; wen3 = 4'h0;
        #1;
        n_vec++;
        if (stall3 !== 1'b0 || rdata3 !== exp3) begin
            n_err++;
            $display("FAIL n3_after_done: got stall=%b rdata=%h expected stall=0 rdata=%h",
                     stall3, rdata3, exp3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en0 = 1'b0; wen0 = '0; addr0 = '0; wdata0 = '0;
        en3 = 1'b0; wen3 = '0; addr3 = '0; wdata3 = '0;
        tick(); tick();
        exp0 = '0; exp3 = '0;
        n_vec++;
        if (rdata0 !== 32'h0 || stall0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_n0: got rdata=%h stall=%b expected 0/0", rdata0, stall0);
        end
        n_vec++;
        if (rdata3 !== 32'h0 || stall3 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_n3: got rdata=%h stall=%b expected 0/0", rdata3, stall3);
        end
`ifdef DSRAM_RANGE_CHECK_EN
        n_vec++;
        if (addr_err0 !== 1'b0 || addr_err3 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_addr_err: got %b%b expected 00", addr_err0, addr_err3);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            acc0(4'hF, make_addr(i), $urandom);
            acc3(4'hF, 32'(i * 4), $urandom);
        end
    endtask

    task automatic test_single_cycle();
        acc0(4'hF, 32'h10, 32'h12345678);
        acc0(4'h0, 32'h10, 32'h0);
        n_vec++;
        if (rdata0 !== 32'h12345678) begin
            n_err++;
            $display("FAIL n0_full_word: got %h expected 12345678", rdata0);
        end
        acc0(4'b0100, 32'h10, 32'h00AB0000);
        acc0(4'h0, 32'h10, 32'h0);
        n_vec++;
        if (rdata0 !== 32'h12AB5678) begin
            n_err++;
            $display("FAIL n0_byte_lane: got %h expected 12AB5678", rdata0);
        end
        acc0(4'hF, 32'h14, 32'hCAFEF00D);
        acc0(4'h0, 32'h10, 32'h0);
        acc0(4'h0, 32'h14, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            int idx;
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) acc0(4'h0, make_addr(idx), 32'h0);
            else acc0(4'($urandom_range(1, 15)), make_addr(idx), $urandom);
        end
    endtask

    task automatic test_wait_states();
        acc3(4'hF, 32'h10, 32'h12345678);
        acc3(4'b0100, 32'h10, 32'h00AB0000);
        acc3(4'h0, 32'h10, 32'h0);
        n_vec++;
        if (rdata3 !== 32'h12AB5678) begin
            n_err++;
            $display("FAIL n3_read_value: got %h expected 12AB5678", rdata3);
        end
        for (int i = 0; i < 10; i++) begin
            int idx;
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) acc3(4'h0, 32'(idx * 4), 32'h0);
            else acc3(4'($urandom_range(1, 15)), 32'(idx * 4), $urandom);
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_reset_mid_access();
        en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h20; wdata3 = 32'hFFFFFFFF;
        #1;
        n_vec++;
        if (stall3 !== 1'b1) begin
            n_err++;
            $display("FAIL n3_idle_stall: got %b expected 1", stall3);
        end
        tick();
        rst = 1'b1; en3 = 1'b0; wen3 = 4'h0;
        tick();
        exp0 = '0; exp3 = '0;
        n_vec++;
        if (stall3 !== 1'b0 || rdata3 !== 32'h0) begin
            n_err++;
            $display("FAIL n3_reset_abort: got stall=%b rdata=%h expected 0/0", stall3, rdata3);
        end
        rst = 1'b0;
        tick();
        acc3(4'h0, 32'h20, 32'h0);
        acc0(4'h0, 32'h20, 32'h0);
    endtask

    task automatic test_range_check();
`ifdef DSRAM_RANGE_CHECK_EN
        en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h1000; wdata0 = 32'hDEADBEEF;
        tick();
        en0 = 1'b0; wen0 = 4'h0;
        n_vec++;
        if (addr_err0 !== 1'b1 || rdata0 !== exp0) begin
            n_err++;
            $display("FAIL range_write_err: got err=%b rdata=%h expected 1/%h", addr_err0, rdata0, exp0);
        end
        tick();
        n_vec++;
        if (addr_err0 !== 1'b0) begin
            n_err++;
            $display("FAIL range_err_pulse: got %b expected 0", addr_err0);
        end
        acc0(4'h0, 32'h0, 32'h0);
        en0 = 1'b1; wen0 = 4'h0; addr0 = 32'h2000;
        tick();
        en0 = 1'b0;
        exp0 = '0;
        n_vec++;
        if (rdata0 !== 32'h0 || addr_err0 !== 1'b1) begin
            n_err++;
            $display("FAIL range_read_zero: got rdata=%h err=%b expected 0/1", rdata0, addr_err0);
        end
        tick();
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_single_cycle();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_access();
        test_range_check();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
